vector_mem_unit: RTL and testbench
==================================

# vector_mem_unit

Parametrised vector load/store engine between the vector register file and the single-port scalar data memory. It serialises one vector memory instruction into per-lane 32-bit accesses and holds the CPU stalled until the instruction finishes. Compared with the fixed 4-lane unit, it adds a lane count parameter, a per-lane enable mask, and a memory `ready` handshake for wait states. It also adds a strided addressing mode alongside per-lane (indexed) addressing.

## Interface
Parameters:
- `N`, 32, lane width and memory address/data width.
- `LANES`, 4, number of lanes; must be ≥ 2.
- `V`, `N*LANES`, vector width; lane i occupies bits `[i*N +: N]`.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin an operation; sampled only in IDLE.
- `we` in 1: 1 = store, 0 = load; captured at start.
- `stride_mode` in 1: 0 = indexed, 1 = strided; captured at start.
- `lane_mask` in LANES: bit i = 1 enables lane i; captured at start.
- `addr_vec` in V: indexed mode gives per-lane addresses. Strided mode uses base = lane 0 and stride = lane 1; captured at start.
- `data_vec` in V: store data per lane; captured at start.
- `mem_rdata` in N: load data, valid when `mem_ready` = 1.
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_req` out 1: access request.
- `mem_wen` out 1: write enable; equals `mem_req & we_reg`.
- `mem_addr` out N: access address.
- `mem_wdata` out N: store data; 0 for loads.
- `result_vec` out V: assembled load result.
- `busy` out 1: stall to CPU.
- `done` out 1: one-cycle completion pulse.

## Operation
- FSM states: IDLE, ACCESS, DONE. `busy` = (state ≠ IDLE).
- IDLE with `start`=1:
  - Capture `we`, `stride_mode`, `lane_mask`, `addr_vec`, `data_vec`.
  - For loads, clear `result_vec` to 0. For stores, `result_vec` holds its value.
  - Set `lane` to the lowest set mask bit and go to ACCESS. If the mask is 0, go straight to DONE with no memory access.
- ACCESS:
  - `mem_req`=1.
  - `mem_addr` = `addr_reg[lane]` in indexed mode. In strided mode it is `base + lane*stride`, truncated to N bits (wraps modulo 2^N). Skipped lanes still count toward `lane*stride`.
  - `mem_wdata` = `data_reg[lane]` if store, else 0.
  - On `mem_ready`=1, a load writes `mem_rdata` into `result_vec[lane]`. Then `lane` advances to the next higher enabled lane; if none remain, go to DONE.
  - On `mem_ready`=0, hold all outputs and `lane` unchanged.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Disabled lanes are never accessed. On a load they read 0 in `result_vec`.
- `start` outside IDLE is ignored; it is neither queued nor re-sampled.
- Captured inputs are ignored after capture. The CPU may change `addr_vec`/`data_vec` mid-operation without effect.
- `result_vec` holds its value in IDLE until the next load starts.

## Timing
- Reset (async assert, any state):
  - State goes to IDLE and `lane`=0.
  - `mem_req`, `mem_wen`, `busy`, `done` = 0; `mem_addr`, `mem_wdata` = 0; `result_vec` = 0.
  - Any in-flight access is abandoned, with no further request.
- All outputs except `result_vec` are decoded combinationally from registered state. In IDLE, `mem_addr`=`mem_wdata`=0.
- `start` sampled at edge k gives `busy`=1 from cycle k+1.
- With M enabled lanes (M ≥ 1) and `mem_ready` held at 1:
  - ACCESS occupies cycles k+1 … k+M, one lane per cycle.
  - DONE occurs in cycle k+M+1.
  - IDLE is reached at k+M+2.
- Each cycle with `mem_ready`=0 in ACCESS adds one cycle of latency.
- Mask = 0: DONE in cycle k+1, IDLE at k+2.
- A load lane's data is visible in `result_vec` the cycle after its `mem_ready` edge. The full result is stable while `done`=1.
- `start` may be asserted in the same cycle the unit returns to IDLE; it is accepted at that edge.

## Test plan
- Indexed load, LANES=4, mask 4'b1111, addresses 0x10/0x14/0x18/0x1C, memory returns 0xA0..0xA3, ready always 1:
  - `mem_addr` sequence is 0x10, 0x14, 0x18, 0x1C on consecutive cycles.
  - `done` pulses at k+5.
  - `result_vec` = {0xA3, 0xA2, 0xA1, 0xA0}.
- Store with mask 4'b1010 and data {D3, D2, D1, D0}, `mem_ready` low for 2 cycles on the first access:
  - Only lanes 1 and 3 are written, with `mem_wen`=1, data D1 then D3.
  - `mem_addr` holds stable during the wait.
  - `done` pulses at k+5.
- Strided load with base 0xFFFF_FFF8, stride 4, mask 4'b1101:
  - Addresses are 0xFFFF_FFF8, 0x0000_0000 (lane 2), 0x0000_0004 (lane 3), showing wrap-around.
  - Lane 1 of `result_vec` = 0.
- Mask = 0 with `start`:
  - No `mem_req`.
  - `busy` high for cycles k+1 only; `done` at k+1.
  - `result_vec` is cleared if the operation is a load.
- `start` re-asserted mid-operation, then `rst` asserted during the third lane access:
  - The second start is ignored.
  - On reset, all outputs go to 0 immediately and the FSM is in IDLE.
  - A new `start` after reset completes normally.
- Back-to-back operations: a store then a load, with `start` held high through completion:
  - The second operation starts in the cycle the unit returns to IDLE.
  - The load reads back the stored values.

Source files
------------

// File: rtl/vector_mem_unit_if.sv
// Bundle of CPU-side control/data and scalar memory bus signals for vector_mem_unit.
// slave is the unit's view; master is the CPU plus memory environment driving it.
interface vector_mem_unit_if #(
  parameter int N     = 32,
  parameter int LANES = 4,
  parameter int V     = N * LANES
);
  logic             start;
  logic             we;
  logic             stride_mode;
  logic [LANES-1:0] lane_mask;
  logic [V-1:0]     addr_vec;
  logic [V-1:0]     data_vec;
  logic [V-1:0]     result_vec;
  logic             busy;
  logic             done;
  logic             mem_req;
  logic             mem_wen;
  logic             mem_ready;
  logic [N-1:0]     mem_addr;
  logic [N-1:0]     mem_wdata;
  logic [N-1:0]     mem_rdata;

  modport master (
    output start, we, stride_mode, lane_mask, addr_vec, data_vec, mem_rdata, mem_ready,
    input  result_vec, busy, done, mem_req, mem_wen, mem_addr, mem_wdata
  );

  modport slave (
    input  start, we, stride_mode, lane_mask, addr_vec, data_vec, mem_rdata, mem_ready,
    output result_vec, busy, done, mem_req, mem_wen, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vector_mem_unit.sv
// Vector load/store engine: serialises one masked vector memory instruction into
// per-lane scalar accesses (indexed or strided) and stalls the CPU until it finishes.
module vector_mem_unit #(
  parameter int N     = 32,
  parameter int LANES = 4,
  parameter int V     = N * LANES
) (
  input logic              clk,
  input logic              rst,
  vector_mem_unit_if.slave bus
);

  localparam int LW = $clog2(LANES);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t           state;
  logic [LW-1:0]    lane;
  logic [LW-1:0]    first_lane;
  logic [LW-1:0]    next_lane;
  logic             has_first;
  logic             has_next;
  logic             we_reg;
  logic             stride_reg;
  logic [LANES-1:0] mask_reg;
  logic [V-1:0]     addr_reg;
  logic [V-1:0]     data_reg;
  logic [V-1:0]     result_reg;
  logic [N-1:0]     base;
  logic [N-1:0]     stride;
  logic [N-1:0]     lane_offset;
  logic [N-1:0]     lane_addr;

  // Lowest enabled lane of the incoming mask; descending scan lets the lowest index win.
  always_comb begin
    first_lane = '0;
    has_first  = 1'b0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (bus.lane_mask[i]) begin
        first_lane = LW'(i);
        has_first  = 1'b1;
      end
    end
  end

  always_comb begin
    next_lane = '0;
    has_next  = 1'b0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask_reg[i] && (i > int'(lane))) begin
        next_lane = LW'(i);
        has_next  = 1'b1;
      end
    end
  end

  // Strided offset uses the raw lane index, so skipped lanes still advance the address.
  assign base        = addr_reg[N-1:0];
  assign stride      = addr_reg[2*N-1:N];
  assign lane_offset = N'(lane) * stride;
  assign lane_addr   = stride_reg ? (base + lane_offset) : addr_reg[int'(lane)*N +: N];

  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);
  assign bus.mem_req    = (state == ACCESS);
  assign bus.mem_wen    = bus.mem_req & we_reg;
  assign bus.mem_addr   = bus.mem_req ? lane_addr : '0;
  assign bus.mem_wdata  = bus.mem_wen ? data_reg[int'(lane)*N +: N] : '0;
  assign bus.result_vec = result_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lane       <= '0;
      we_reg     <= 1'b0;
      stride_reg <= 1'b0;
      mask_reg   <= '0;
      addr_reg   <= '0;
      data_reg   <= '0;
      result_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            we_reg     <= bus.we;
            stride_reg <= bus.stride_mode;
            mask_reg   <= bus.lane_mask;
            addr_reg   <= bus.addr_vec;
            data_reg   <= bus.data_vec;
            if (!bus.we) begin
              result_reg <= '0;
            end
            lane  <= first_lane;
            state <= has_first ? ACCESS : DONE;
          end
        end
        ACCESS: begin
          if (bus.mem_ready) begin
            if (!we_reg) begin
              result_reg[int'(lane)*N +: N] <= bus.mem_rdata;
            end
            if (has_next) begin
              lane <= next_lane;
            end else begin
              state <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_mem_unit.sv
// Scoreboard bench for vector_mem_unit: stimulus queues expected accesses and completions,
// a negedge monitor pops and compares them against the bus as the DUT presents them.
module tb_vector_mem_unit;

  localparam int N     = 32;
  localparam int LANES = 4;
  localparam int V     = N * LANES;

  typedef struct {
    logic [N-1:0] addr;
    logic         wen;
    logic [N-1:0] wdata;
  } acc_t;

  typedef struct {
    int           cyc;
    logic [V-1:0] res;
  } done_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  acc_t  exp_acc[$];
  done_t exp_done[$];

  logic [N-1:0] mem [0:255];
  logic         pre_we;
  logic [N-1:0] pre_addr;
  logic [N-1:0] pre_data;
  logic         stall_load;
  int           stall_val;
  int           stall_left;

  vector_mem_unit_if #(.N(N), .LANES(LANES)) bus ();

  vector_mem_unit #(.N(N), .LANES(LANES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Word-addressed memory model with programmable wait states on the next access.
  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];
  assign bus.mem_ready = (stall_left == 0);

  always @(posedge clk) begin
    if (bus.mem_req && bus.mem_ready && bus.mem_wen) begin
      mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end else if (pre_we) begin
      mem[pre_addr[9:2]] <= pre_data;
    end
    if (stall_load) begin
      stall_left <= stall_val;
    end else if (bus.mem_req && stall_left != 0) begin
      stall_left <= stall_left - 1;
    end
  end

  task automatic checkOutput(input string name, input logic [V-1:0] actual, input logic [V-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: requests must match the queue head every cycle (stable while stalled).
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_req) begin
        if (exp_acc.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_req: got addr %0h expected no request", bus.mem_addr);
        end else begin
          checkOutput("mem_addr", V'(bus.mem_addr), V'(exp_acc[0].addr));
          checkOutput("mem_wen", V'(bus.mem_wen), V'(exp_acc[0].wen));
          checkOutput("mem_wdata", V'(bus.mem_wdata), V'(exp_acc[0].wdata));
          if (bus.mem_ready) begin
            void'(exp_acc.pop_front());
          end
        end
      end
      if (bus.done) begin
        if (exp_done.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done: got done at cycle %0d expected none", cyc);
        end else begin
          checkOutput("done_cycle", V'(cyc), V'(exp_done[0].cyc));
          checkOutput("result_vec", bus.result_vec, exp_done[0].res);
          void'(exp_done.pop_front());
        end
      end
    end
  end

  task automatic pushAccess(input logic [N-1:0] addr, input logic wen, input logic [N-1:0] wdata);
    acc_t a;
    a.addr  = addr;
    a.wen   = wen;
    a.wdata = wdata;
    exp_acc.push_back(a);
  endtask

  task automatic pushDone(input int at_cyc, input logic [V-1:0] res);
    done_t d;
    d.cyc = at_cyc;
    d.res = res;
    exp_done.push_back(d);
  endtask

  task automatic preload(input logic [N-1:0] addr, input logic [N-1:0] data);
    @(negedge clk);
    pre_addr = addr;
    pre_data = data;
    pre_we   = 1'b1;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  // Drives one instruction; returns k, the index of the edge that samples start.
  task automatic applyStimulus(input logic w, input logic sm, input logic [LANES-1:0] mask,
                               input logic [V-1:0] av, input logic [V-1:0] dv,
                               input int stalls, input bit hold, output int k);
    @(negedge clk);
    bus.we          = w;
    bus.stride_mode = sm;
    bus.lane_mask   = mask;
    bus.addr_vec    = av;
    bus.data_vec    = dv;
    stall_val       = stalls;
    stall_load      = 1'b1;
    bus.start       = 1'b1;
    k               = cyc;
    @(posedge clk);
    #1;
    stall_load = 1'b0;
    if (!hold) begin
      bus.start    = 1'b0;
      bus.addr_vec = ~av;
      bus.data_vec = ~dv;
    end
  endtask

  task automatic waitIdle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy && n < 50);
    checkOutput("idle_timeout", V'(bus.busy), '0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_mem_req"}, V'(bus.mem_req), '0);
    checkOutput({tag, "_mem_wen"}, V'(bus.mem_wen), '0);
    checkOutput({tag, "_busy"}, V'(bus.busy), '0);
    checkOutput({tag, "_done"}, V'(bus.done), '0);
    checkOutput({tag, "_mem_addr"}, V'(bus.mem_addr), '0);
    checkOutput({tag, "_mem_wdata"}, V'(bus.mem_wdata), '0);
    checkOutput({tag, "_result_vec"}, bus.result_vec, '0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    int k2;
    checks          = 0;
    errors          = 0;
    cyc             = 0;
    rst             = 1'b1;
    bus.start       = 1'b0;
    bus.we          = 1'b0;
    bus.stride_mode = 1'b0;
    bus.lane_mask   = '0;
    bus.addr_vec    = '0;
    bus.data_vec    = '0;
    pre_we          = 1'b0;
    pre_addr        = '0;
    pre_data        = '0;
    stall_load      = 1'b0;
    stall_val       = 0;
    #12;
    checkAllZero("reset");
    @(negedge clk);
    rst = 1'b0;

    preload(32'h10, 32'hA0);
    preload(32'h14, 32'hA1);
    preload(32'h18, 32'hA2);
    preload(32'h1C, 32'hA3);
    preload(32'hFFFF_FFF8, 32'h11);
    preload(32'hFFFF_FFFC, 32'h99);
    preload(32'h0, 32'h22);
    preload(32'h4, 32'h33);
    preload(32'h40, 32'h50);
    preload(32'h44, 32'h51);

    $display("[TB] indexed load, all lanes");
    pushAccess(32'h10, 1'b0, 32'h0);
    pushAccess(32'h14, 1'b0, 32'h0);
    pushAccess(32'h18, 1'b0, 32'h0);
    pushAccess(32'h1C, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 4'b1111, {32'h1C, 32'h18, 32'h14, 32'h10}, '0, 0, 1'b0, k);
    pushDone(k + 5, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    waitIdle();

    $display("[TB] masked store with wait states");
    pushAccess(32'h104, 1'b1, 32'hD000_0001);
    pushAccess(32'h10C, 1'b1, 32'hD000_0003);
    applyStimulus(1'b1, 1'b0, 4'b1010, {32'h10C, 32'h108, 32'h104, 32'h100},
                  {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000}, 2, 1'b0, k);
    pushDone(k + 5, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    waitIdle();

    $display("[TB] strided load with address wrap");
    pushAccess(32'hFFFF_FFF8, 1'b0, 32'h0);
    pushAccess(32'h0, 1'b0, 32'h0);
    pushAccess(32'h4, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 4'b1101, {32'hBAD, 32'hBAD, 32'h4, 32'hFFFF_FFF8}, '0, 0, 1'b0, k);
    pushDone(k + 4, {32'h33, 32'h22, 32'h0, 32'h11});
    waitIdle();

    $display("[TB] empty mask load");
    applyStimulus(1'b0, 1'b0, 4'b0000, {32'h10, 32'h10, 32'h10, 32'h10}, '0, 0, 1'b0, k);
    pushDone(k + 1, '0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("mask0_busy_k2", V'(bus.busy), '0);
    waitIdle();

    $display("[TB] restart ignored, reset mid-operation");
    pushAccess(32'h40, 1'b0, 32'h0);
    pushAccess(32'h44, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 4'b1111, {32'h4C, 32'h48, 32'h44, 32'h40}, '0, 0, 1'b0, k);
    bus.start     = 1'b1;
    bus.lane_mask = 4'b0001;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkAllZero("async_rst");
    @(negedge clk);
    #1 rst = 1'b0;
    pushAccess(32'h40, 1'b0, 32'h0);
    pushAccess(32'h44, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 4'b0011, {32'h4C, 32'h48, 32'h44, 32'h40}, '0, 0, 1'b0, k);
    pushDone(k + 3, {32'h0, 32'h0, 32'h51, 32'h50});
    waitIdle();

    $display("[TB] back-to-back store then load");
    pushAccess(32'h200, 1'b1, 32'h11);
    pushAccess(32'h204, 1'b1, 32'h22);
    pushAccess(32'h208, 1'b1, 32'h33);
    pushAccess(32'h20C, 1'b1, 32'h44);
    pushAccess(32'h200, 1'b0, 32'h0);
    pushAccess(32'h204, 1'b0, 32'h0);
    pushAccess(32'h208, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 4'b1111, {32'h20C, 32'h208, 32'h204, 32'h200},
                  {32'h44, 32'h33, 32'h22, 32'h11}, 0, 1'b1, k);
    k2 = k + 6;
    pushDone(k + 5, {32'h0, 32'h0, 32'h51, 32'h50});
    pushDone(k2 + 4, {32'h0, 32'h33, 32'h22, 32'h11});
    bus.we        = 1'b0;
    bus.lane_mask = 4'b0111;
    bus.data_vec  = '0;
    repeat (6) @(posedge clk);
    #1 bus.start = 1'b0;
    waitIdle();

    repeat (3) @(negedge clk);
    checkOutput("acc_queue_empty", V'(exp_acc.size()), '0);
    checkOutput("done_queue_empty", V'(exp_done.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
